// File: rtl/siebensegment_scan.sv
// Time-multiplexed seven-segment driver: hex decode, per-digit blanking and
// decimal point, PWM brightness within each digit slot, frame-done pulse.
module siebensegment_scan #(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [3:0]            brightness,
  output logic [6:0]            segmente,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    presc_reg, presc_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [4*DIGITS-1:0] data_sh_reg;
  logic [DIGITS-1:0]   dp_sh_reg, blank_sh_reg;
  logic [6:0]          seg_reg, seg_next;
  logic                dp_out_reg, dp_out_next;
  logic [DIGITS-1:0]   anode_reg, anode_next;
  logic                frame_done_reg, frame_done_next;

  logic                tick;
  logic                lit;
  logic [3:0]          nib_sel;
  logic [DIGITS-1:0]   sel;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // One-hot digit select keeps every per-digit lookup free of index-width issues.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
    assign sel[gi] = (idx_reg == IDX_W'(gi));
  end

  always_comb begin
    presc_next      = presc_reg + DIV_W'(1);
    tick            = &presc_reg;
    idx_next        = idx_reg;
    if (tick) idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
    frame_done_next = tick && (idx_reg == LAST_IDX);

    nib_sel = 4'h0;
    for (int i = 0; i < DIGITS; i++)
      if (sel[i]) nib_sel = data_sh_reg[4*i +: 4];

    // PWM compares the top prescaler nibble, so duty is brightness/16 of a slot.
    lit         = (presc_reg[DIV_W-1 -: 4] < brightness) && !(|(sel & blank_sh_reg));
    anode_next  = lit ? ~sel : '1;
    seg_next    = lit ? ~hex7(nib_sel) : 7'h7F;
    dp_out_next = lit ? ~(|(sel & dp_sh_reg)) : 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg      <= '0;
      idx_reg        <= '0;
      data_sh_reg    <= '0;
      dp_sh_reg      <= '0;
      blank_sh_reg   <= '1;
      seg_reg        <= 7'h7F;
      dp_out_reg     <= 1'b1;
      anode_reg      <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      idx_reg        <= idx_next;
      seg_reg        <= seg_next;
      dp_out_reg     <= dp_out_next;
      anode_reg      <= anode_next;
      frame_done_reg <= frame_done_next;
      if (load) begin
        data_sh_reg  <= data;
        dp_sh_reg    <= dp;
        blank_sh_reg <= blank;
      end
    end
  end

  assign segmente   = seg_reg;
  assign dp_out     = dp_out_reg;
  assign anode      = anode_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_siebensegment_scan.sv
// Directed bench: a 4-digit/DIV_W=4 scanner and a 1-digit/DIV_W=5 scanner,
// checked cycle by cycle against the decode table and slot timing.
module tb_siebensegment_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load;
  logic [15:0] data;
  logic [3:0]  dp, blank, brightness;
  logic [6:0]  segmente;
  logic        dp_out;
  logic [3:0]  anode;
  logic        frame_done;

  logic        reset1, load1;
  logic [3:0]  data1;
  logic        dp1, blank1;
  logic [3:0]  brightness1;
  logic [6:0]  segmente1;
  logic        dp_out1;
  logic        anode1;
  logic        frame_done1;

  siebensegment_scan #(.DIGITS(4), .DIV_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .load(load), .data(data), .dp(dp), .blank(blank),
    .brightness(brightness), .segmente(segmente), .dp_out(dp_out), .anode(anode),
    .frame_done(frame_done)
  );

  siebensegment_scan #(.DIGITS(1), .DIV_W(5)) u_dut1 (
    .clk(clk), .reset(reset1), .load(load1), .data(data1), .dp(dp1), .blank(blank1),
    .brightness(brightness1), .segmente(segmente1), .dp_out(dp_out1), .anode(anode1),
    .frame_done(frame_done1)
  );

  // Active-high gfedcba codes for hex 0..F.
  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] e_data;
  logic [3:0]  e_dp, e_blank;
  logic        e_blank1;
  int lowcnt [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Expected outputs of the 4-digit unit after edge number cyc since release.
  task automatic chk_a();
    int p, d;
    logic lit;
    logic [3:0] e_an;
    logic [6:0] e_sg;
    logic e_dpo;
    p     = (cyc - 1) % 16;
    d     = ((cyc - 1) / 16) % 4;
    lit   = (p < int'(brightness)) && !e_blank[d];
    e_an  = lit ? ~(4'b0001 << d) : 4'hF;
    e_sg  = lit ? ~hex7[e_data[4*d +: 4]] : 7'h7F;
    e_dpo = lit ? ~e_dp[d] : 1'b1;
    check("anode", 32'(anode), 32'(e_an));
    check("segmente", 32'(segmente), 32'(e_sg));
    check("dp_out", 32'(dp_out), 32'(e_dpo));
    check("frame_done", 32'(frame_done), 32'(cyc % 64 == 0));
  endtask

  task automatic chk_b();
    logic lit;
    lit = ((((cyc - 1) % 32) / 2) < int'(brightness1)) && !e_blank1;
    check("anode1", 32'(anode1), 32'(!lit));
    check("segmente1", 32'(segmente1), 32'(lit ? 7'h00 : 7'h7F));
    check("dp_out1", 32'(dp_out1), 32'(!lit));
    check("frame_done1", 32'(frame_done1), 32'(cyc % 32 == 0));
  endtask

  task automatic dark_a(input string tag);
    check({tag, "_anode"}, 32'(anode), 32'h0000_000F);
    check({tag, "_seg"}, 32'(segmente), 32'h0000_007F);
    check({tag, "_dp"}, 32'(dp_out), 32'h0000_0001);
    check({tag, "_fd"}, 32'(frame_done), 32'h0000_0000);
  endtask

  task automatic reset_a();
    reset = 1'b0;
    #1;
    dark_a("rst_now");
    e_data = 16'h0; e_dp = 4'h0; e_blank = 4'hF;
    repeat (3) begin
      @(negedge clk);
      dark_a("rst_hold");
    end
    reset = 1'b1;
    cyc = 0;
    $display("reset released");
  endtask

  task automatic load_a(input logic [15:0] dv, input logic [3:0] dpv, input logic [3:0] bv);
    data = dv; dp = dpv; blank = bv; load = 1'b1;
    step();
    chk_a();
    load = 1'b0;
    e_data = dv; e_dp = dpv; e_blank = bv;
    $display("load data=%h dp=%b blank=%b at cycle %0d", dv, dpv, bv, cyc);
  endtask

  always @(negedge clk) check("onehot_anode", 32'($countones(~anode) <= 1), 32'h1);

  initial begin
    reset = 1'b1; reset1 = 1'b1; load = 1'b0; load1 = 1'b0;
    data = 16'h0; dp = 4'h0; blank = 4'h0; brightness = 4'd15;
    data1 = 4'h0; dp1 = 1'b0; blank1 = 1'b0; brightness1 = 4'd0;
    e_blank1 = 1'b1;
    #2;
    reset1 = 1'b0;
    reset_a();
    check("dut1_rst_anode", 32'(anode1), 32'h1);
    check("dut1_rst_seg", 32'(segmente1), 32'h7F);

    // Shadows still blanked from reset: dark for 200 cycles, frame_done every 64.
    repeat (200) begin step(); chk_a(); end
    $display("idle scan done at cycle %0d", cyc);

    load_a(16'h3A10, 4'b0100, 4'b0000);
    repeat (128) begin step(); chk_a(); end

    brightness = 4'd4;
    while (cyc % 64 != 0) begin step(); chk_a(); end
    for (int i = 0; i < 4; i++) lowcnt[i] = 0;
    repeat (64) begin
      step(); chk_a();
      for (int i = 0; i < 4; i++) lowcnt[i] += (anode[i] == 1'b0) ? 1 : 0;
    end
    for (int i = 0; i < 4; i++) check("bright4_lowcnt", 32'(lowcnt[i]), 32'd4);
    $display("brightness 4 frame done at cycle %0d", cyc);

    brightness = 4'd0;
    repeat (64) begin step(); chk_a(); end

    brightness = 4'd15;
    load_a(16'h3A10, 4'b0100, 4'b1010);
    while (cyc % 64 != 5) begin step(); chk_a(); end
    load_a(16'h3A17, 4'b0100, 4'b1010);
    step(); chk_a();
    check("midload_seg", 32'(segmente), 32'h78);
    for (int i = 0; i < 4; i++) lowcnt[i] = 0;
    repeat (128) begin
      step(); chk_a();
      for (int i = 0; i < 4; i++) lowcnt[i] += (anode[i] == 1'b0) ? 1 : 0;
    end
    check("blank_d1_lowcnt", 32'(lowcnt[1]), 32'd0);
    check("blank_d3_lowcnt", 32'(lowcnt[3]), 32'd0);
    check("unblank_d0_lowcnt", 32'(lowcnt[0]), 32'd30);

    while (cyc % 64 != 40) begin step(); chk_a(); end
    check("pre_reset_d2_lit", 32'(anode), 32'hB);
    reset_a();
    load_a(16'h3A10, 4'b0100, 4'b0000);
    step(); chk_a();
    check("after_reset_d0_first", 32'(anode), 32'hE);
    repeat (68) begin step(); chk_a(); end
    $display("reset recovery done at cycle %0d", cyc);

    // Single-digit unit: release and load on the same first edge.
    data1 = 4'h8; dp1 = 1'b1; blank1 = 1'b0; brightness1 = 4'd8; load1 = 1'b1;
    reset1 = 1'b1;
    cyc = 0;
    step(); chk_b();
    load1 = 1'b0; e_blank1 = 1'b0;
    repeat (100) begin step(); chk_b(); end
    $display("single digit run done at cycle %0d", cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/siebensegment_scan.md
SIEBENSEGMENT_SCAN -- requirements
Module: siebensegment_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter DIV_W, default 15, prescaler width; one digit slot lasts 2^DIV_W clk cycles; legal range 4..24.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset; 0 forces the reset state immediately.
REQ-005 SHALL have port load, input, 1, one-cycle strobe that captures data/dp/blank into shadow registers.
REQ-006 SHALL have port data, input, 4*DIGITS, hex nibble per digit; digit i is data[4i+3:4i].
REQ-007 SHALL have port dp, input, DIGITS, decimal point request per digit; 1 = lit.
REQ-008 SHALL have port blank, input, DIGITS, per-digit blanking; 1 = digit dark.
REQ-009 SHALL have port brightness, input, 4, PWM duty level 0..15, sampled live, not shadowed.
REQ-010 SHALL have port segmente, output, 7, active-low segments; bit0 = a ... bit6 = g.
REQ-011 SHALL have port dp_out, output, 1, active-low decimal point.
REQ-012 SHALL have port anode, output, DIGITS, active-low digit enables; bit i drives digit i.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each full scan.

Function
REQ-014 SHALL run a DIV_W-bit prescaler incrementing every cycle and wrapping from 2^DIV_W-1 to 0.
REQ-015 SHALL assert an internal tick when the prescaler equals 2^DIV_W-1.
REQ-016 SHALL hold a digit index 0..DIGITS-1 that advances by one on each tick and wraps DIGITS-1 -> 0.
REQ-017 SHALL pulse frame_done high for exactly one cycle, registered, in the cycle after a tick that wraps the index to 0.
REQ-018 SHALL, on load=1, capture data, dp and blank into shadow registers at that clock edge; display uses shadows only.
REQ-019 SHALL make loads mid-slot take effect on the current digit from the next cycle; no other hold-off applies.
REQ-020 SHALL decode the selected shadow nibble, active-high gfedcba hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; segmente = bitwise inverse.
REQ-021 SHALL define "on" as: top 4 prescaler bits < brightness AND shadow blank[index]=0.
REQ-022 SHALL, when on, drive anode with only bit index low, segmente per REQ-020, and dp_out = ~dp[index].
REQ-023 SHALL, when not on, drive anode all ones, segmente 7'h7F and dp_out 1.
REQ-024 SHALL register segmente, dp_out and anode, so outputs reflect index and prescaler of the previous cycle (latency 1).
REQ-025 SHALL, with brightness=0, keep the display dark; with brightness=15, keep the digit lit 15/16 of each slot.
REQ-026 SHALL, with DIGITS=1, keep the index at 0 and pulse frame_done on every tick.
REQ-027 SHALL never assert more than one anode bit low in any cycle.

Reset
REQ-028 SHALL, while reset=0, set prescaler=0, index=0, shadow data=0, shadow dp=0, shadow blank=all ones.
REQ-029 SHALL, while reset=0, drive anode all ones, segmente 7'h7F, dp_out 1, frame_done 0.
REQ-030 SHALL resume from index 0, prescaler 0 on the first edge after reset release; a reset mid-slot or mid-frame discards all progress.

Verification (DIGITS=4, DIV_W=4 unless noted)
REQ-031 SHALL cover: reset, no load -> anode=4'hF, segmente=7'h7F for 200 cycles; frame_done pulses every 64 cycles.
REQ-032 SHALL cover: load data=16'h3A10, blank=0, dp=4'b0100, brightness=15 -> digits 0..3 show 0,1,A,3; segmente 7'h40,7'h79,7'h08,7'h30; dp_out=0 only during digit 2.
REQ-033 SHALL cover: brightness=4 -> each anode low for exactly 4 cycles per 16-cycle slot; brightness=0 -> anode=4'hF always.
REQ-034 SHALL cover: blank=4'b1010 -> anode bits 1 and 3 never low; load of new data mid-slot changes segmente one cycle after the load edge.
REQ-035 SHALL cover: reset pulled low in the middle of digit 2 -> outputs dark immediately; after release, digit 0 lit first, frame_done 64 cycles later.
REQ-036 SHALL cover: DIGITS=1, DIV_W=5 -> anode toggles only bit 0; frame_done every 32 cycles; one-hot-low anode check holds in all runs.
